// File: rtl/lfsr_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_stream_if
//  Brief    : Control and valid/ready stream bundle for lfsr_stream.
//             The master side is the LFSR source and the slave side is the
//             consumer that seeds, steers and drains it.
//  Revision : 1.0  initial release
// ============================================================================
interface lfsr_stream_if #(
  parameter int WIDTH = 8
);
  // Consumer-driven controls
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             free_run;
  logic             rnd_ready;

  // Source-driven stream and status
  logic [WIDTH-1:0] rnd_out;
  logic             rnd_valid;
  logic             wrap;
  logic             zero_fix;
  logic [WIDTH-1:0] step_cnt;

  modport master (
    input  seed_load,
    input  seed_in,
    input  free_run,
    input  rnd_ready,
    output rnd_out,
    output rnd_valid,
    output wrap,
    output zero_fix,
    output step_cnt
  );

  modport slave (
    output seed_load,
    output seed_in,
    output free_run,
    output rnd_ready,
    input  rnd_out,
    input  rnd_valid,
    input  wrap,
    input  zero_fix,
    input  step_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_stream.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_stream
//  Brief    : Registered Fibonacci LFSR pseudo-random source presented as a
//             valid/ready stream. Advances on handshake or in free-run mode,
//             supports runtime reseeding, repairs the all-zero lock-up state
//             and pulses when the sequence returns to its active seed.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_stream #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input wire logic      clk,
  input wire logic      rst,
  lfsr_stream_if.master bus
);

  localparam logic [WIDTH-1:0] c_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Architectural state
  logic [WIDTH-1:0] r_state;        // current LFSR word, also the output word
  logic [WIDTH-1:0] r_active_seed;  // value whose recurrence marks one period
  logic [WIDTH-1:0] r_step_cnt;     // advances since last seed/reset/wrap
  logic             r_valid;        // low only during the first cycle after reset
  logic             r_wrap;
  logic             r_zero_fix;

  // Next-state helpers
  logic             w_feedback;
  logic [WIDTH-1:0] w_next;
  logic             w_advance;
  logic             w_seed_is_zero;
  logic [WIDTH-1:0] w_load_value;
  logic             w_state_is_zero;
  logic             w_hit_seed;
  logic [WIDTH-1:0] w_cnt_inc;

  // Feedback is the parity of the tapped state bits, shifted in at the LSB.
  assign w_feedback      = ^(r_state & TAPS);
  assign w_next          = {r_state[WIDTH-2:0], w_feedback};

  // The stream only moves once a word is on offer; free_run ignores the
  // consumer and skips words without a handshake.
  assign w_advance       = r_valid & (bus.free_run | bus.rnd_ready);

  // An all-zero seed would lock the register, so it is replaced by SEED.
  assign w_seed_is_zero  = (bus.seed_in == c_ZERO);
  assign w_load_value    = w_seed_is_zero ? SEED : bus.seed_in;

  // Zero state cannot be reached from a legal seed; treated as corruption.
  assign w_state_is_zero = (r_state == c_ZERO);

  // Period completion is detected on the word about to be produced, so the
  // wrap pulse lines up with the cycle the seed reappears on rnd_out.
  assign w_hit_seed      = (w_next == r_active_seed);
  assign w_cnt_inc       = r_step_cnt + c_ONE;

  // State update: seed load has priority over advance, advance over hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= SEED;
      r_active_seed <= SEED;
      r_step_cnt    <= c_ZERO;
      r_valid       <= 1'b0;
      r_wrap        <= 1'b0;
      r_zero_fix    <= 1'b0;
    end else begin
      // Pulses default low every cycle and are raised only by the event below.
      r_valid    <= 1'b1;
      r_wrap     <= 1'b0;
      r_zero_fix <= 1'b0;

      if (bus.seed_load) begin
        // Any simultaneous transfer is honoured by the old word; no advance.
        r_state       <= w_load_value;
        r_active_seed <= w_load_value;
        r_step_cnt    <= c_ZERO;
        r_zero_fix    <= w_seed_is_zero;
      end else if (w_advance) begin
        if (w_state_is_zero) begin
          r_state       <= SEED;
          r_active_seed <= SEED;
          r_step_cnt    <= c_ZERO;
          r_zero_fix    <= 1'b1;
        end else begin
          r_state <= w_next;
          if (w_hit_seed) begin
            r_wrap     <= 1'b1;
            r_step_cnt <= c_ZERO;
          end else begin
            r_step_cnt <= w_cnt_inc;
          end
        end
      end
    end
  end

  // All outputs come straight from registers.
  assign bus.rnd_out   = r_state;
  assign bus.rnd_valid = r_valid;
  assign bus.wrap      = r_wrap;
  assign bus.zero_fix  = r_zero_fix;
  assign bus.step_cnt  = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_stream
//  Brief    : Scoreboard bench for lfsr_stream (8-bit B8 and 4-bit C
//             instances). The driver pushes expected words; monitors pop and
//             compare on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_stream;

  localparam logic [7:0] c_TAPS8 = 8'hB8;
  localparam logic [7:0] c_SEED8 = 8'h01;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  lfsr_stream_if #(.WIDTH(8)) bus8 ();
  lfsr_stream_if #(.WIDTH(4)) bus4 ();

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.master)
  );

  lfsr_stream #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       valid;
    logic [7:0] cnt;
    logic       wrap;
    logic       zfix;
  } exp8_t;

  typedef struct {
    logic [3:0] out;
    logic [3:0] cnt;
    logic       wrap;
  } exp4_t;

  exp8_t q8[$];
  exp4_t q4[$];

  // Reference state for the 8-bit instance
  logic [7:0] m_state;
  logic [7:0] m_active;
  logic [7:0] m_cnt;
  bit         m_valid;

  // Period bookkeeping from observed DUT words
  bit track;
  bit seen[256];
  int distinct;
  int wraps_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor for the 8-bit stream
  always @(negedge clk) begin : p_mon8
    exp8_t e;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk({e.name, "/out"},   32'(bus8.rnd_out),   32'(e.out));
      chk({e.name, "/valid"}, 32'(bus8.rnd_valid), 32'(e.valid));
      chk({e.name, "/cnt"},   32'(bus8.step_cnt),  32'(e.cnt));
      chk({e.name, "/wrap"},  32'(bus8.wrap),      32'(e.wrap));
      chk({e.name, "/zfix"},  32'(bus8.zero_fix),  32'(e.zfix));
    end
    if (track && bus8.rnd_valid) begin
      if (!seen[bus8.rnd_out]) begin
        seen[bus8.rnd_out] = 1'b1;
        distinct++;
      end
      if (bus8.wrap) wraps_seen++;
    end
  end

  // Monitor for the 4-bit stream
  always @(negedge clk) begin : p_mon4
    exp4_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("w4/out",  32'(bus4.rnd_out),  32'(e.out));
      chk("w4/cnt",  32'(bus4.step_cnt), 32'(e.cnt));
      chk("w4/wrap", 32'(bus4.wrap),     32'(e.wrap));
    end
  end

  task automatic model_reset();
    m_state  = c_SEED8;
    m_active = c_SEED8;
    m_cnt    = 8'h00;
    m_valid  = 1'b0;
  endtask

  task automatic push_reset(input string name);
    exp8_t e;
    e.name = name; e.out = c_SEED8; e.valid = 1'b0;
    e.cnt = 8'h00; e.wrap = 1'b0; e.zfix = 1'b0;
    q8.push_back(e);
    @(negedge clk); #1;
  endtask

  // One clock of stimulus; hout/hcnt >= 0 give hand-computed expectations.
  task automatic cyc(input string name, input bit load, input logic [7:0] sin,
                     input bit fr, input bit rdy, input int hout, input int hcnt);
    exp8_t      e;
    bit         adv;
    logic [7:0] n;
    bus8.seed_load = load;
    bus8.seed_in   = sin;
    bus8.free_run  = fr;
    bus8.rnd_ready = rdy;
    e.wrap = 1'b0;
    e.zfix = 1'b0;
    adv = m_valid & (fr | rdy);
    if (load) begin
      m_state  = (sin == 8'h00) ? c_SEED8 : sin;
      m_active = m_state;
      m_cnt    = 8'h00;
      e.zfix   = (sin == 8'h00);
    end else if (adv) begin
      n = {m_state[6:0], ^(m_state & c_TAPS8)};
      m_state = n;
      if (n == m_active) begin
        e.wrap = 1'b1;
        m_cnt  = 8'h00;
      end else begin
        m_cnt = m_cnt + 8'h01;
      end
    end
    m_valid = 1'b1;
    e.name  = name;
    e.valid = 1'b1;
    e.out   = (hout >= 0) ? 8'(hout) : m_state;
    e.cnt   = (hcnt >= 0) ? 8'(hcnt) : m_cnt;
    q8.push_back(e);
    @(negedge clk); #1;
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : p_drive
    logic [3:0] tbl4[15];
    exp4_t      e4;
    tbl4 = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    n_checks = 0; n_pass = 0;
    track = 1'b0; distinct = 0; wraps_seen = 0;
    bus8.seed_load = 1'b0; bus8.seed_in = 8'h00; bus8.free_run = 1'b0; bus8.rnd_ready = 1'b0;
    bus4.seed_load = 1'b0; bus4.seed_in = 4'h0; bus4.free_run = 1'b0; bus4.rnd_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    push_reset("rst_a");
    push_reset("rst_b");
    rst = 1'b0;
    track = 1'b1;

    // Opening sequence with continuous ready
    cyc("seq0", 0, 8'h00, 0, 1, 8'h01, 0);
    cyc("seq1", 0, 8'h00, 0, 1, 8'h02, 1);
    cyc("seq2", 0, 8'h00, 0, 1, 8'h04, 2);
    cyc("seq3", 0, 8'h00, 0, 1, 8'h08, 3);
    cyc("seq4", 0, 8'h00, 0, 1, 8'h11, 4);
    cyc("seq5", 0, 8'h00, 0, 1, 8'h23, 5);
    cyc("seq6", 0, 8'h00, 0, 1, 8'h47, 6);
    // Rest of the full period: advances 7..254, then 255 returns to 01
    for (int i = 7; i < 255; i++) cyc("period", 0, 8'h00, 0, 1, -1, -1);
    cyc("period_end", 0, 8'h00, 0, 1, 8'h01, 0);
    track = 1'b0;
    chk("distinct_words", 32'(distinct), 32'd255);
    chk("wrap_pulses", 32'(wraps_seen), 32'd1);

    // Stalled consumer, no free run: everything frozen
    for (int i = 0; i < 10; i++) cyc("hold", 0, 8'h00, 0, 0, 8'h01, 0);
    // Free run without ready advances every cycle
    cyc("free1", 0, 8'h00, 1, 0, 8'h02, 1);
    cyc("free2", 0, 8'h00, 1, 0, 8'h04, 2);
    cyc("free3", 0, 8'h00, 1, 0, 8'h08, 3);
    cyc("free4", 0, 8'h00, 1, 0, 8'h11, 4);
    cyc("free5", 0, 8'h00, 1, 0, 8'h23, 5);

    // Zero seed with simultaneous transfer: substitute SEED, no advance
    cyc("zseed", 1, 8'h00, 0, 1, 8'h01, 0);
    cyc("zseed_after", 0, 8'h00, 0, 0, 8'h01, 0);

    // Reseed with A5 and run one full period back to A5
    cyc("a5_load", 1, 8'hA5, 0, 0, 8'hA5, 0);
    cyc("a5_next", 0, 8'h00, 0, 1, 8'h4A, 1);
    for (int i = 2; i < 255; i++) cyc("a5_period", 0, 8'h00, 0, 1, -1, -1);
    cyc("a5_wrap", 0, 8'h00, 0, 1, 8'hA5, 0);
    cyc("pre_rst1", 0, 8'h00, 0, 1, 8'h4A, 1);
    cyc("pre_rst2", 0, 8'h00, 0, 1, 8'h95, 2);

    // Asynchronous reset between edges: outputs clear without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst/out",   32'(bus8.rnd_out),   32'h01);
    chk("async_rst/valid", 32'(bus8.rnd_valid), 32'h0);
    chk("async_rst/cnt",   32'(bus8.step_cnt),  32'h0);
    chk("async_rst/wrap",  32'(bus8.wrap),      32'h0);
    chk("async_rst/zfix",  32'(bus8.zero_fix),  32'h0);
    model_reset();
    @(negedge clk); #1;
    push_reset("rst_mid_hold");
    rst = 1'b0;
    cyc("restart0", 0, 8'h00, 0, 1, 8'h01, 0);
    cyc("restart1", 0, 8'h00, 0, 1, 8'h02, 1);
    cyc("restart2", 0, 8'h00, 0, 1, 8'h04, 2);
    bus8.rnd_ready = 1'b0;

    // 4-bit instance, TAPS=C: period 15, wrap every 15 advances
    bus4.free_run = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      e4.out  = tbl4[k % 15];
      e4.cnt  = 4'(k % 15);
      e4.wrap = ((k % 15) == 0);
      q4.push_back(e4);
      @(negedge clk); #1;
    end
    bus4.free_run = 1'b0;

    @(negedge clk); #1;
    chk("queues_drained", 32'(q8.size() + q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
